serial_parity_transmitter: RTL
==============================

# serial_parity_transmitter

Transmit side of the serial even-parity link. Accepts a parallel word on a load handshake and shifts it out LSB-first on a single serial line, one bit per clock, followed by one even-parity bit. A downstream serial parity detector that starts in its EVEN state and clocks in one whole frame (data bits plus parity bit) ends in EVEN, so its output z = 0. The block sits between a word-level producer and the serial line.

## Interface

Parameters:
- WIDTH, default 8, number of data bits per frame; legal range is 2 or more.

Ports:
- clock  input  1  single clock; all state updates on the posedge.
- reset_n  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  word to transmit; sampled only on an accepted load.
- load  input  1  request to start a frame.
- ready  output  1  high when the block is idle and can accept a load.
- x  output  1  serial data line; registered.
- frame  output  1  high during every cycle in which x carries a frame bit; registered.
- done  output  1  single-cycle pulse in the parity-bit cycle; registered.

## Operation

- States:
  - IDLE.
  - START (present only with the macro; see Configuration).
  - DATA.
  - PARITY.
- ready = (state == IDLE). It is a combinational decode of the state register only.
- IDLE:
  - Drives x=0, frame=0, done=0.
  - If load=1 at a posedge: latch data_in into the shift register, clear the bit counter, clear the running parity, then go to DATA.
  - If load=0, remain in IDLE.
- DATA:
  - Each cycle drives x = shreg[0] and frame=1.
  - Running parity updates as p <= p ^ shreg[0].
  - The shift register shifts right by 1.
  - The counter increments. After the cycle with count == WIDTH-1, go to PARITY.
- PARITY:
  - Drives x = XOR of all WIDTH data bits (even parity: total ones in the frame is even), frame=1, done=1.
  - Next state is IDLE unconditionally.
- load is ignored whenever ready=0. A load held high through a frame has no effect until IDLE.
- data_in changes after the load edge do not affect the frame in flight.
- Counter width is $clog2(WIDTH). The counter must not wrap mid-frame for any legal WIDTH.
- Reset (asserted at any time, including mid-frame):
  - State goes to IDLE immediately; the frame is aborted with no parity bit sent.
  - x=0, frame=0, done=0, ready=1.
  - Shift register, counter and running parity are cleared.

## Timing

- The load is accepted at posedge N. The first data bit (data_in[0]) appears on x after posedge N, i.e. in cycle N+1.
- Data bit k appears in cycle N+1+k. The parity bit appears in cycle N+1+WIDTH, with done=1.
- ready returns to 1 in cycle N+2+WIDTH.
- Frame length is WIDTH+1 cycles.
- Minimum spacing between frames is one idle cycle (x=0, frame=0): for back-to-back loads, the next frame's first bit is in cycle N+3+WIDTH.
- Deassertion of reset_n takes effect at the next posedge. The earliest load accepted is at the first posedge with reset_n=1.

## Configuration

- Macro: SERIAL_PARITY_TX_START_BIT_EN.
- Defined:
  - An accepted load goes to START instead of DATA.
  - START drives x=1, frame=1 for one cycle, then goes to DATA.
  - The start bit is excluded from the parity.
  - All data, parity, done and ready timings shift one cycle later; frame length becomes WIDTH+2.
- Undefined: the START state and its logic are not compiled. Timing is exactly as specified above.

## Test plan

- Reset behaviour: assert reset_n=0 with load=1 and random data_in -> x=0, frame=0, done=0, ready=1 throughout. After release, the first load is accepted.
- Even-weight word: WIDTH=8, load data_in=8'hB4 -> x = 0,0,1,0,1,1,0,1 then parity 0. frame=1 for 9 cycles; done=1 only on the 9th cycle. A detector fed x in frame cycles ends with z=0.
- Odd-weight word: data_in=8'h07 -> x = 1,1,1,0,0,0,0,0 then parity 1. ready=0 for 9 cycles, then returns to 1.
- Load while busy: load=1 held continuously with data_in 8'hFF then 8'h01 after the first edge -> first frame is 8'hFF with parity 0. One idle cycle follows; the second frame then carries whatever data_in holds at that IDLE edge.
- Mid-frame reset: assert reset_n in the 4th data cycle -> outputs go to x=0, frame=0, ready=1 immediately with no done pulse. A fresh load of 8'h01 then sends 1,0,0,0,0,0,0,0 with parity 1.
- With SERIAL_PARITY_TX_START_BIT_EN: data_in=8'h07 -> x = 1 (start), then 1,1,1,0,0,0,0,0, then parity 1. frame=1 for 10 cycles; done is on the 10th cycle.

Source files
------------

// File: rtl/serial_parity_transmitter.sv
// Serial even-parity transmitter: LSB-first data bits then one parity bit (optional start bit under SERIAL_PARITY_TX_START_BIT_EN).
// Latency: first data bit on x the cycle after the load edge; frame is WIDTH+1 cycles (WIDTH+2 with start bit).
// Backpressure: ready is low for the whole frame; load is ignored while ready=0.
module serial_parity_transmitter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             x,
  output logic             frame,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
`ifdef SERIAL_PARITY_TX_START_BIT_EN
    ,
    START  = 2'd3
`endif
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             p;

  assign ready = (state == IDLE);

  // Outputs are registered, so each branch loads the value x must carry in the next cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      p     <= 1'b0;
      x     <= 1'b0;
      frame <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          x     <= 1'b0;
          frame <= 1'b0;
          done  <= 1'b0;
          if (load) begin
            shreg <= data_in;
            cnt   <= '0;
            p     <= 1'b0;
            frame <= 1'b1;
`ifdef SERIAL_PARITY_TX_START_BIT_EN
            state <= START;
            x     <= 1'b1;
`else
            state <= DATA;
            x     <= data_in[0];
`endif
          end
        end
`ifdef SERIAL_PARITY_TX_START_BIT_EN
        START: begin
          state <= DATA;
          x     <= shreg[0];
          frame <= 1'b1;
        end
`endif
        DATA: begin
          p     <= p ^ shreg[0];
          shreg <= shreg >> 1;
          frame <= 1'b1;
          if (cnt == LAST) begin
            // Counter holds on the last bit so it never wraps.
            state <= PARITY;
            x     <= p ^ shreg[0];
            done  <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            x     <= shreg[1];
          end
        end
        PARITY: begin
          state <= IDLE;
          x     <= 1'b0;
          frame <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          x     <= 1'b0;
          frame <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
